// File: rtl/decode_ctrl_pipe.sv
// decode_ctrl_pipe -- registered RV32I decode stage (IF/ID -> ID/EX).
//
// Purpose: decodes a raw RV32I instruction into the execute-stage control
// bundle and holds it in a one-entry valid/ready pipeline register. Adds
// load-use bubble insertion, flush and illegal-instruction flagging.
// Optional build macro RVM_MULDIV_EN: decodes RV32M (ALU_Control 16+funct3)
// and stalls input for DIV_LAT cycles after any DIV/DIVU/REM/REMU issue.
// With the macro undefined, RV32M encodings are illegal and no divider
// state machine or counter exists.
//
// Handshake: an input transfer happens on a clock edge where
// in_valid && in_ready; an output transfer happens where out_valid && out_ready.
// While out_valid && !out_ready, every output is held stable.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   in_valid/in_ready   input handshake for instr/pc_in
//   instr, pc_in        raw instruction and its PC
//   flush               redirect: kills the registered instruction
//   out_ready/out_valid output handshake for the control bundle
//   pc_out, rs1/rs2/rd  registered PC and register indices
//   Reg_write, Mem_Write, jump, Branch, Alu_src, Result_src, Imm_src,
//   ALU_Control, Load_type, Store_type, branch_cond, illegal
//                       registered control bundle
//   dbg_state_o         divider FSM state (1 = DIV_BUSY), 0 when not built
module decode_ctrl_pipe #(
  parameter int XLEN    = 32,
  parameter int DIV_LAT = 8,
  parameter int CNT_W   = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] pc_in,
  input  logic            flush,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] pc_out,
  output logic [4:0]      rs1,
  output logic [4:0]      rs2,
  output logic [4:0]      rd,
  output logic            Reg_write,
  output logic            Mem_Write,
  output logic            jump,
  output logic            Branch,
  output logic            Alu_src,
  output logic [1:0]      Result_src,
  output logic [2:0]      Imm_src,
  output logic [4:0]      ALU_Control,
  output logic [2:0]      Load_type,
  output logic [1:0]      Store_type,
  output logic [2:0]      branch_cond,
  output logic            illegal,
  output logic            dbg_state_o
);

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef struct packed {
    logic       reg_write;
    logic       mem_write;
    logic       jump;
    logic       branch;
    logic       alu_src;
    logic [1:0] result_src;
    logic [2:0] imm_src;
    logic [4:0] alu_ctrl;
    logic [2:0] load_type;
    logic [1:0] store_type;
    logic [2:0] branch_cond;
    logic       illegal;
  } ctrl_t;

  logic [6:0] opc;
  logic [2:0] funct3;
  logic [6:0] funct7;
  assign opc    = instr[6:0];
  assign funct3 = instr[14:12];
  assign funct7 = instr[31:25];

  // ALU op shared by OP (funct7=0) and OP-IMM, indexed by funct3.
  function automatic logic [4:0] base_alu(input logic [2:0] f3);
    case (f3)
      3'd0:    base_alu = 5'd0;  // ADD
      3'd1:    base_alu = 5'd5;  // SLL
      3'd2:    base_alu = 5'd8;  // SLT
      3'd3:    base_alu = 5'd9;  // SLTU
      3'd4:    base_alu = 5'd4;  // XOR
      3'd5:    base_alu = 5'd6;  // SRL
      3'd6:    base_alu = 5'd3;  // OR
      default: base_alu = 5'd2;  // AND
    endcase
  endfunction

  ctrl_t dec;
  logic  ill;

  always_comb begin
    dec = '0;
    ill = 1'b0;
    case (opc)
      OPC_LUI: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'd3;
        dec.alu_ctrl  = 5'd10;
      end
      OPC_AUIPC: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'd3;
      end
      OPC_JAL: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.imm_src    = 3'd4;
      end
      OPC_JALR: begin
        dec.reg_write  = 1'b1;
        dec.jump       = 1'b1;
        dec.result_src = 2'b10;
        dec.alu_src    = 1'b1;
        ill            = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        dec.branch  = 1'b1;
        dec.imm_src = 3'd2;
        case (funct3)
          3'b000:  begin dec.branch_cond = 3'd0; dec.alu_ctrl = 5'd1; end
          3'b001:  begin dec.branch_cond = 3'd1; dec.alu_ctrl = 5'd1; end
          3'b100:  begin dec.branch_cond = 3'd2; dec.alu_ctrl = 5'd8; end
          3'b101:  begin dec.branch_cond = 3'd3; dec.alu_ctrl = 5'd8; end
          3'b110:  begin dec.branch_cond = 3'd4; dec.alu_ctrl = 5'd9; end
          3'b111:  begin dec.branch_cond = 3'd5; dec.alu_ctrl = 5'd9; end
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        dec.reg_write  = 1'b1;
        dec.alu_src    = 1'b1;
        dec.result_src = 2'b01;
        case (funct3)
          3'b000:  dec.load_type = 3'd2;  // LB
          3'b001:  dec.load_type = 3'd1;  // LH
          3'b010:  dec.load_type = 3'd0;  // LW
          3'b100:  dec.load_type = 3'd7;  // LBU
          3'b101:  dec.load_type = 3'd3;  // LHU
          default: ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        dec.mem_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.imm_src   = 3'd1;
        case (funct3)
          3'b000:  dec.store_type = 2'd2;  // SB
          3'b001:  dec.store_type = 2'd1;  // SH
          3'b010:  dec.store_type = 2'd0;  // SW
          default: ill = 1'b1;
        endcase
      end
      OPC_OPIMM: begin
        dec.reg_write = 1'b1;
        dec.alu_src   = 1'b1;
        dec.alu_ctrl  = base_alu(funct3);
        // Shift-immediates carry a funct7 in imm[11:5]; only SRAI may set bit 30.
        if (funct3 == 3'd1) begin
          ill = (funct7 != 7'b0000000);
        end else if (funct3 == 3'd5) begin
          if (funct7 == 7'b0100000) dec.alu_ctrl = 5'd7;
          else if (funct7 != 7'b0000000) ill = 1'b1;
        end
      end
      OPC_OP: begin
        dec.reg_write = 1'b1;
        if (funct7 == 7'b0000000) begin
          dec.alu_ctrl = base_alu(funct3);
        end else if (funct7 == 7'b0100000) begin
          if (funct3 == 3'd0) dec.alu_ctrl = 5'd1;
          else if (funct3 == 3'd5) dec.alu_ctrl = 5'd7;
          else ill = 1'b1;
        end else if (funct7 == 7'b0000001) begin
`ifdef RVM_MULDIV_EN
          dec.alu_ctrl = {2'b10, funct3};
`else
          ill = 1'b1;
`endif
        end else begin
          ill = 1'b1;
        end
      end
      default: ill = 1'b1;
    endcase
    // An illegal instruction must not write anything or redirect control.
    if (ill) begin
      dec         = '0;
      dec.illegal = 1'b1;
    end
  end

  // Source-register usage of the incoming instruction, for the load-use check.
  logic rs1_used, rs2_used;
  assign rs1_used = !((opc == OPC_LUI) || (opc == OPC_AUIPC) || (opc == OPC_JAL));
  assign rs2_used = (opc == OPC_OP) || (opc == OPC_STORE) || (opc == OPC_BRANCH);

  logic            out_valid_q;
  ctrl_t           ctrl_q;
  logic [XLEN-1:0] pc_q;
  logic [4:0]      rs1_q, rs2_q, rd_q;

  logic hz, adv, fire, run;

  assign hz = out_valid_q && (ctrl_q.result_src == 2'b01) && (rd_q != 5'd0) &&
              ((rs1_used && (instr[19:15] == rd_q)) ||
               (rs2_used && (instr[24:20] == rd_q)));
  assign adv      = out_ready || !out_valid_q;
  assign in_ready = adv && !hz && run && !flush;
  assign fire     = in_valid && in_ready;

`ifdef RVM_MULDIV_EN
  typedef enum logic {ST_RUN = 1'b0, ST_DIV_BUSY = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             is_div;

  assign is_div      = (opc == OPC_OP) && (funct7 == 7'b0000001) && funct3[2];
  assign run         = (state_q == ST_RUN);
  assign dbg_state_o = (state_q == ST_DIV_BUSY);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (flush) begin
      state_d = ST_RUN;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (fire && is_div) begin
            state_d = ST_DIV_BUSY;
            cnt_d   = CNT_W'(DIV_LAT);
          end
        end
        ST_DIV_BUSY: begin
          // Counter value is the number of busy cycles left, this one included.
          if (cnt_q == CNT_W'(1)) begin
            state_d = ST_RUN;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = ST_RUN;
          cnt_d   = '0;
        end
      endcase
    end
  end
`else
  logic [31:0] unused_cfg;
  assign unused_cfg  = DIV_LAT + CNT_W;
  assign run         = 1'b1;
  assign dbg_state_o = 1'b0;
`endif

  // Pipeline register: flush wins, then capture, then drain when advancing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
    end else if (flush) begin
      out_valid_q <= 1'b0;
    end else if (fire) begin
      out_valid_q <= 1'b1;
      ctrl_q      <= dec;
      pc_q        <= pc_in;
      rs1_q       <= instr[19:15];
      rs2_q       <= instr[24:20];
      rd_q        <= instr[11:7];
    end else if (adv) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid   = out_valid_q;
  assign pc_out      = pc_q;
  assign rs1         = rs1_q;
  assign rs2         = rs2_q;
  assign rd          = rd_q;
  assign Reg_write   = ctrl_q.reg_write;
  assign Mem_Write   = ctrl_q.mem_write;
  assign jump        = ctrl_q.jump;
  assign Branch      = ctrl_q.branch;
  assign Alu_src     = ctrl_q.alu_src;
  assign Result_src  = ctrl_q.result_src;
  assign Imm_src     = ctrl_q.imm_src;
  assign ALU_Control = ctrl_q.alu_ctrl;
  assign Load_type   = ctrl_q.load_type;
  assign Store_type  = ctrl_q.store_type;
  assign branch_cond = ctrl_q.branch_cond;
  assign illegal     = ctrl_q.illegal;

endmodule

// File: tb/tb_decode_ctrl_pipe.sv
// Testbench for decode_ctrl_pipe: directed steps from the test plan followed
// by random traffic, all checked against a mnemonic-level reference model.
module tb_decode_ctrl_pipe;
  localparam int XLEN    = 32;
  localparam int DIV_LAT = 8;
  localparam int BW      = 71;

`ifdef RVM_MULDIV_EN
  localparam bit MULDIV_ON = 1'b1;
`else
  localparam bit MULDIV_ON = 1'b0;
`endif

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic        reg_write;
    logic        mem_write;
    logic        jump;
    logic        branch;
    logic        alu_src;
    logic [1:0]  result_src;
    logic [2:0]  imm_src;
    logic [4:0]  alu;
    logic [2:0]  load_type;
    logic [1:0]  store_type;
    logic [2:0]  bcond;
    logic        illegal;
  } bundle_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid = 1'b0, in_ready;
  logic [31:0]     instr = '0;
  logic [XLEN-1:0] pc_in = '0;
  logic            flush = 1'b0, out_ready = 1'b0, out_valid;
  logic [XLEN-1:0] pc_out;
  logic [4:0]      o_rs1, o_rs2, o_rd;
  logic            o_reg_write, o_mem_write, o_jump, o_branch, o_alu_src;
  logic [1:0]      o_result_src;
  logic [2:0]      o_imm_src;
  logic [4:0]      o_alu;
  logic [2:0]      o_load_type;
  logic [1:0]      o_store_type;
  logic [2:0]      o_bcond;
  logic            o_illegal;
  logic            dbg_state;

  decode_ctrl_pipe #(.XLEN(XLEN), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .instr(instr), .pc_in(pc_in),
    .flush(flush), .out_ready(out_ready), .out_valid(out_valid),
    .pc_out(pc_out), .rs1(o_rs1), .rs2(o_rs2), .rd(o_rd),
    .Reg_write(o_reg_write), .Mem_Write(o_mem_write), .jump(o_jump),
    .Branch(o_branch), .Alu_src(o_alu_src), .Result_src(o_result_src),
    .Imm_src(o_imm_src), .ALU_Control(o_alu), .Load_type(o_load_type),
    .Store_type(o_store_type), .branch_cond(o_bcond), .illegal(o_illegal),
    .dbg_state_o(dbg_state)
  );

  bundle_t dut_b;
  assign dut_b = {pc_out, o_rs1, o_rs2, o_rd, o_reg_write, o_mem_write, o_jump,
                  o_branch, o_alu_src, o_result_src, o_imm_src, o_alu,
                  o_load_type, o_store_type, o_bcond, o_illegal};

  // ---------------- scoreboard ----------------
  logic [BW-1:0] exp_q[$];
  int busy_left = 0;
  int total = 0;
  int bad = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic string mnemonic(input logic [31:0] ins);
    logic [6:0] opc = ins[6:0];
    logic [2:0] f3  = ins[14:12];
    logic [6:0] f7  = ins[31:25];
    string br[8]  = '{"BEQ", "BNE", "ILL", "ILL", "BLT", "BGE", "BLTU", "BGEU"};
    string ld[8]  = '{"LB", "LH", "LW", "ILL", "LBU", "LHU", "ILL", "ILL"};
    string st[8]  = '{"SB", "SH", "SW", "ILL", "ILL", "ILL", "ILL", "ILL"};
    string opi[8] = '{"ADDI", "SLLI", "SLTI", "SLTIU", "XORI", "SRLI", "ORI", "ANDI"};
    string op[8]  = '{"ADD", "SLL", "SLT", "SLTU", "XOR", "SRL", "OR", "AND"};
    string mop[8] = '{"MUL", "MULH", "MULHSU", "MULHU", "DIV", "DIVU", "REM", "REMU"};
    if (opc == 7'h37) return "LUI";
    if (opc == 7'h17) return "AUIPC";
    if (opc == 7'h6F) return "JAL";
    if (opc == 7'h67) begin
      if (f3 == 3'd0) return "JALR";
      return "ILL";
    end
    if (opc == 7'h63) return br[f3];
    if (opc == 7'h03) return ld[f3];
    if (opc == 7'h23) return st[f3];
    if (opc == 7'h13) begin
      if (f3 == 3'd1 && f7 != 7'h00) return "ILL";
      if (f3 == 3'd5 && f7 == 7'h20) return "SRAI";
      if (f3 == 3'd5 && f7 != 7'h00) return "ILL";
      return opi[f3];
    end
    if (opc == 7'h33) begin
      if (f7 == 7'h00) return op[f3];
      if (f7 == 7'h20 && f3 == 3'd0) return "SUB";
      if (f7 == 7'h20 && f3 == 3'd5) return "SRA";
      if (f7 == 7'h01 && MULDIV_ON) return mop[f3];
      return "ILL";
    end
    return "ILL";
  endfunction

  function automatic int alu_code(input string m);
    case (m)
      "ADD", "ADDI":   return 0;
      "SUB":           return 1;
      "AND", "ANDI":   return 2;
      "OR", "ORI":     return 3;
      "XOR", "XORI":   return 4;
      "SLL", "SLLI":   return 5;
      "SRL", "SRLI":   return 6;
      "SRA", "SRAI":   return 7;
      "SLT", "SLTI":   return 8;
      "SLTU", "SLTIU": return 9;
      "MUL":           return 16;
      "MULH":          return 17;
      "MULHSU":        return 18;
      "MULHU":         return 19;
      "DIV":           return 20;
      "DIVU":          return 21;
      "REM":           return 22;
      "REMU":          return 23;
      default:         return 0;
    endcase
  endfunction

  function automatic bundle_t exp_bundle(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t b = '0;
    string m = mnemonic(ins);
    b.pc  = pc;
    b.rs1 = ins[19:15];
    b.rs2 = ins[24:20];
    b.rd  = ins[11:7];
    case (m)
      "ILL":   b.illegal = 1'b1;
      "LUI":   begin b.reg_write = 1; b.alu_src = 1; b.imm_src = 3; b.alu = 10; end
      "AUIPC": begin b.reg_write = 1; b.alu_src = 1; b.imm_src = 3; end
      "JAL":   begin b.reg_write = 1; b.jump = 1; b.result_src = 2; b.imm_src = 4; end
      "JALR":  begin b.reg_write = 1; b.jump = 1; b.result_src = 2; b.alu_src = 1; end
      "BEQ":   begin b.branch = 1; b.imm_src = 2; b.bcond = 0; b.alu = 1; end
      "BNE":   begin b.branch = 1; b.imm_src = 2; b.bcond = 1; b.alu = 1; end
      "BLT":   begin b.branch = 1; b.imm_src = 2; b.bcond = 2; b.alu = 8; end
      "BGE":   begin b.branch = 1; b.imm_src = 2; b.bcond = 3; b.alu = 8; end
      "BLTU":  begin b.branch = 1; b.imm_src = 2; b.bcond = 4; b.alu = 9; end
      "BGEU":  begin b.branch = 1; b.imm_src = 2; b.bcond = 5; b.alu = 9; end
      "LW":    begin b.reg_write = 1; b.alu_src = 1; b.result_src = 1; b.load_type = 0; end
      "LH":    begin b.reg_write = 1; b.alu_src = 1; b.result_src = 1; b.load_type = 1; end
      "LB":    begin b.reg_write = 1; b.alu_src = 1; b.result_src = 1; b.load_type = 2; end
      "LHU":   begin b.reg_write = 1; b.alu_src = 1; b.result_src = 1; b.load_type = 3; end
      "LBU":   begin b.reg_write = 1; b.alu_src = 1; b.result_src = 1; b.load_type = 7; end
      "SW":    begin b.mem_write = 1; b.alu_src = 1; b.imm_src = 1; b.store_type = 0; end
      "SH":    begin b.mem_write = 1; b.alu_src = 1; b.imm_src = 1; b.store_type = 1; end
      "SB":    begin b.mem_write = 1; b.alu_src = 1; b.imm_src = 1; b.store_type = 2; end
      "ADDI", "SLTI", "SLTIU", "XORI", "ORI", "ANDI", "SLLI", "SRLI", "SRAI": begin
        b.reg_write = 1; b.alu_src = 1; b.alu = 5'(alu_code(m));
      end
      default: begin b.reg_write = 1; b.alu = 5'(alu_code(m)); end
    endcase
    return b;
  endfunction

  function automatic bit uses_rs1(input logic [31:0] ins);
    string m = mnemonic(ins);
    return !(m == "LUI" || m == "AUIPC" || m == "JAL");
  endfunction

  function automatic bit uses_rs2(input logic [31:0] ins);
    // R-type, stores and branches read rs2, whether or not funct fields are legal.
    return (ins[6:0] == 7'h33) || (ins[6:0] == 7'h23) || (ins[6:0] == 7'h63);
  endfunction

  function automatic bit is_div(input logic [31:0] ins);
    string m = mnemonic(ins);
    return (m == "DIV" || m == "DIVU" || m == "REM" || m == "REMU");
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [4:0]  a   = 5'($urandom_range(0, 3));
    logic [4:0]  b   = 5'($urandom_range(0, 3));
    logic [4:0]  d   = 5'($urandom_range(0, 3));
    logic [2:0]  f3  = 3'($urandom_range(0, 7));
    logic [11:0] imm = 12'($urandom);
    int sel = int'($urandom_range(0, 11));
    if (sel == 0) return {7'h00, b, a, f3, d, 7'h33};
    if (sel == 1) return {7'h20, b, a, f3, d, 7'h33};
    if (sel == 2) return {7'h01, b, a, f3, d, 7'h33};
    if (sel == 3) begin
      if ($urandom_range(0, 2) == 0) imm[11:5] = 7'h20;
      else if (f3 == 3'd1 || f3 == 3'd5) imm[11:5] = 7'h00;
      return {imm, a, f3, d, 7'h13};
    end
    if (sel == 4) return {imm, a, f3, d, 7'h03};
    if (sel == 5) return {imm[11:5], b, a, f3, imm[4:0], 7'h23};
    if (sel == 6) return {imm[11:5], b, a, f3, imm[4:0], 7'h63};
    if (sel == 7) return {imm, a, f3, d, 7'h37};
    if (sel == 8) return {imm, a, f3, d, 7'h17};
    if (sel == 9) return {imm, a, f3, d, 7'h6F};
    if (sel == 10) return {imm, a, f3, d, 7'h67};
    return $urandom;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic ordy, input logic fl);
    in_valid  = v;
    instr     = ins;
    pc_in     = pc;
    out_ready = ordy;
    flush     = fl;
  endtask

  // Entered 1 time unit after a rising edge with inputs applied; checks the
  // cycle against the model, steps the model across the edge, returns 1 unit
  // after the next rising edge.
  task automatic cycle();
    bundle_t     h;
    logic        exp_valid, hz_m, adv_m, exp_rdy;
    logic        s_valid, s_flush, s_ordy;
    logic [31:0] s_instr, s_pc;
    #2;
    exp_valid = (exp_q.size() != 0);
    chk("out_valid", 128'(out_valid), 128'(exp_valid));
    h = '0;
    if (exp_valid) begin
      h = exp_q[0];
      chk("bundle", 128'(dut_b), 128'(h));
    end
    hz_m = exp_valid && (h.result_src == 2'd1) && (h.rd != 5'd0) &&
           ((uses_rs1(instr) && instr[19:15] == h.rd) || (uses_rs2(instr) && instr[24:20] == h.rd));
    adv_m   = out_ready || !exp_valid;
    exp_rdy = adv_m && !hz_m && (busy_left == 0) && !flush;
    chk("in_ready", 128'(in_ready), 128'(exp_rdy));
    chk("dbg_state", 128'(dbg_state), 128'(busy_left != 0));
    s_valid = in_valid; s_flush = flush; s_ordy = out_ready;
    s_instr = instr;    s_pc = pc_in;
    @(posedge clk);
    if (s_flush) begin
      exp_q.delete();
      busy_left = 0;
    end else begin
      if (exp_valid && s_ordy) void'(exp_q.pop_front());
      if (busy_left > 0) busy_left--;
      if (s_valid && exp_rdy) begin
        exp_q.push_back(BW'(exp_bundle(s_instr, s_pc)));
        if (is_div(s_instr)) busy_left = DIV_LAT;
      end
    end
    #1;
  endtask

  localparam logic [31:0] I_ADDI  = 32'h00500093;  // addi x1,x0,5
  localparam logic [31:0] I_LW    = 32'h0000A103;  // lw   x2,0(x1)
  localparam logic [31:0] I_ADD   = 32'h002101B3;  // add  x3,x2,x2
  localparam logic [31:0] I_BLTU  = 32'h0020E063;  // bltu x1,x2,0
  localparam logic [31:0] I_SW    = 32'h0020A223;  // sw   x2,4(x1)
  localparam logic [31:0] I_ADDI2 = 32'h00708213;  // addi x4,x1,7
  localparam logic [31:0] I_BAD   = 32'h0000007F;
  localparam logic [31:0] I_MUL   = 32'h027302B3;  // mul  x5,x6,x7
  localparam logic [31:0] I_MUL2  = 32'h02730433;  // mul  x8,x6,x7
  localparam logic [31:0] I_DIV   = 32'h027342B3;  // div  x5,x6,x7

  // ---------------- stimulus ----------------
  initial begin
    drive(0, '0, '0, 0, 0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_bundle", 128'(dut_b), 128'(0));
    chk("rst_state", 128'(dbg_state), 128'(0));
    rst = 1'b0;

    // ADDI, single-cycle latency
    drive(1, I_ADDI, 32'h100, 1, 0); cycle();
    chk("addi_valid", 128'(out_valid), 128'(1));
    chk("addi_rw", 128'(o_reg_write), 128'(1));
    chk("addi_alusrc", 128'(o_alu_src), 128'(1));
    chk("addi_alu", 128'(o_alu), 128'(0));
    chk("addi_rd", 128'(o_rd), 128'(1));
    chk("addi_illegal", 128'(o_illegal), 128'(0));

    // load-use: one bubble between LW and dependent ADD
    drive(1, I_LW, 32'h104, 1, 0); cycle();
    chk("lw_ressrc", 128'(o_result_src), 128'(1));
    chk("lw_ldtype", 128'(o_load_type), 128'(0));
    drive(1, I_ADD, 32'h108, 1, 0); #1;
    chk("lu_ready", 128'(in_ready), 128'(0));
    cycle();
    chk("bubble_valid", 128'(out_valid), 128'(0));
    cycle();
    chk("add_valid", 128'(out_valid), 128'(1));
    chk("add_rs1", 128'(o_rs1), 128'(2));
    chk("add_rs2", 128'(o_rs2), 128'(2));

    // backpressure holding a BLTU
    drive(1, I_BLTU, 32'h10C, 1, 0); cycle();
    drive(1, I_SW, 32'h110, 0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_ready", 128'(in_ready), 128'(0));
      chk("bltu_alu", 128'(o_alu), 128'(9));
      chk("bltu_cond", 128'(o_bcond), 128'(4));
      chk("bltu_imm", 128'(o_imm_src), 128'(2));
      cycle();
    end

    // flush while SW waits
    drive(1, I_SW, 32'h110, 1, 0); cycle();
    chk("sw_mw", 128'(o_mem_write), 128'(1));
    drive(1, I_ADDI2, 32'h114, 0, 0); cycle();
    drive(1, I_ADDI2, 32'h114, 0, 1); cycle();
    chk("flush_valid", 128'(out_valid), 128'(0));
    #1;
    chk("flush_ready", 128'(in_ready), 128'(0));
    cycle();
    chk("flush_nocap", 128'(out_valid), 128'(0));
    drive(1, I_ADDI2, 32'h114, 1, 0); cycle();
    chk("post_flush_valid", 128'(out_valid), 128'(1));
    chk("post_flush_pc", 128'(pc_out), 128'(32'h114));

    // illegal opcode and RV32M handling
    drive(1, I_BAD, 32'h118, 1, 0); cycle();
    chk("bad_illegal", 128'(o_illegal), 128'(1));
    chk("bad_rw", 128'(o_reg_write), 128'(0));
    chk("bad_mw", 128'(o_mem_write), 128'(0));
    drive(1, I_MUL, 32'h11C, 1, 0); cycle();
`ifdef RVM_MULDIV_EN
    chk("mul_alu", 128'(o_alu), 128'(16));
    chk("mul_illegal", 128'(o_illegal), 128'(0));
    drive(1, I_DIV, 32'h120, 1, 0); cycle();
    chk("div_alu", 128'(o_alu), 128'(20));
    drive(1, I_MUL, 32'h124, 1, 0);
    for (int i = 0; i < DIV_LAT; i++) begin
      #1;
      chk("div_stall", 128'(in_ready), 128'(0));
      chk("div_state", 128'(dbg_state), 128'(1));
      cycle();
    end
    #1;
    chk("div_done", 128'(in_ready), 128'(1));
    cycle();
    chk("mul_after_div", 128'(o_alu), 128'(16));
    drive(1, I_MUL2, 32'h128, 1, 0); #1;
    chk("mul_nostall", 128'(in_ready), 128'(1));
    cycle();
    chk("mul2_rd", 128'(o_rd), 128'(8));
`else
    chk("mul_illegal", 128'(o_illegal), 128'(1));
    chk("mul_rw", 128'(o_reg_write), 128'(0));
    drive(1, I_DIV, 32'h120, 1, 0); cycle();
    chk("div_illegal", 128'(o_illegal), 128'(1));
    drive(1, I_MUL, 32'h124, 1, 0); #1;
    chk("div_nostall", 128'(in_ready), 128'(1));
    cycle();
`endif

    // random traffic
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(0, 3) != 0, rand_instr(), $urandom,
            $urandom_range(0, 9) < 7, $urandom_range(0, 19) == 0);
      cycle();
    end
    drive(0, '0, '0, 1, 0);
    repeat (3) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/decode_ctrl_pipe.md
Name: decode_ctrl_pipe

Overview:
- Registered RV32I decode stage: instruction in, decoded control bundle out through a one-entry valid/ready pipeline register (IF/ID → ID/EX).
- Adds sequential behaviour to pure opcode decode: backpressure, load-use bubble insertion, flush, and illegal-instruction flagging.
- Optionally decodes RV32M and enforces a multi-cycle divider structural stall.
- Sits between the fetch buffer and the execute stage of the 5-stage core.

Parameters:
- XLEN, 32, width of pc_in/pc_out.
- DIV_LAT, 8, cycles the divider occupies after a DIV/DIVU/REM/REMU issue (≥1).
- CNT_W, 4, width of the divide busy counter (2^CNT_W > DIV_LAT).

Ports:
- clk  in  1  core clock.
- rst  in  1  asynchronous active-high reset.
- in_valid  in  1  instr/pc_in valid.
- in_ready  out  1  stage accepts input this cycle.
- instr  in  32  raw instruction.
- pc_in  in  XLEN  instruction PC.
- flush  in  1  branch/jump redirect; kill the registered instruction.
- out_ready  in  1  execute stage accepts the bundle.
- out_valid  out  1  bundle valid.
- pc_out  out  XLEN  registered PC.
- rs1, rs2, rd  out  5 each  register indices.
- Reg_write, Mem_Write, jump, Branch, Alu_src  out  1 each.
- Result_src  out  2  00 ALU, 01 MEM, 10 PC+4.
- Imm_src  out  3  I=0, S=1, B=2, U=3, J=4.
- ALU_Control  out  5  ADD 0, SUB 1, AND 2, OR 3, XOR 4, SLL 5, SRL 6, SRA 7, SLT 8, SLTU 9, LUI-pass 10, M-ops 16–23 (MUL..REMU in funct3 order).
- Load_type  out  3  W 0, H 1, B 2, HU 3, BU 7.
- Store_type  out  2  W 0, H 1, B 2.
- branch_cond  out  3  EQ 0, NE 1, LT 2, GE 3, LTU 4, GEU 5.
- illegal  out  1  undecodable instruction.

Behaviour:
- Interface: one clock (clk); reset (rst) asynchronous, active-high.
- Reset: out_valid=0, every control output 0, pc_out/rs/rd 0, state RUN, counter 0.
- Decode is combinational from instr. Every field has a default (0 / ADD / W / EQ), so there are no latches.
- R-type decodes all 10 ops including XOR.
- LUI: ALU_Control=10, Alu_src=1.
- Branch ALU op: BEQ/BNE → SUB; BLT/BGE → SLT; BLTU/BGEU → SLTU.
- Unknown opcode, or unknown funct7/funct3 combination: illegal=1, Reg_write=0, Mem_Write=0, Branch=0, jump=0.
- Register-use flags: rs1 used by all opcodes except LUI, AUIPC, JAL. rs2 used by R-type, STORE, BRANCH.
- Capture: fire = in_valid && in_ready. On fire the bundle is registered, out_valid←1; latency is 1 cycle.
- Advance: adv = out_ready || !out_valid. If adv && !fire, then out_valid←0.
- Load-use hazard: hz = out_valid && Result_src==MEM && rd!=0 && (rs1 used && rs1==rd || rs2 used && rs2==rd), comparing the incoming instr's sources against the registered rd.
- in_ready = adv && !hz && state==RUN && !flush.
- On hz && out_ready: exactly one bubble (out_valid=0); the instruction is accepted the following cycle.
- flush has top priority: out_valid←0 next edge, no capture that cycle, state←RUN, counter←0.
- out_valid && !out_ready: all outputs held stable.
- State machine, RUN / DIV_BUSY, only with RVM_MULDIV_EN:
  - RUN→DIV_BUSY on fire of a DIV/DIVU/REM/REMU; counter←DIV_LAT.
  - DIV_BUSY: counter decrements each cycle; at counter==1 → RUN. in_ready=0 throughout.
  - MUL* ops never stall.
  - Reset or flush mid-busy returns to RUN immediately.
- Simultaneous flush and hz: flush wins; no bubble bookkeeping carries over.

Optional Feature:
- RVM_MULDIV_EN defined: opcode 0110011 with funct7=0000001 decodes to ALU_Control 16+funct3, Reg_write=1, with the DIV_BUSY stall.
- RVM_MULDIV_EN undefined: those encodings set illegal=1; state stays RUN; no counter logic is synthesised.

Test Plan:
- Reset, then ADDI x1,x0,5 (0x00500093) with out_ready=1 → next cycle out_valid=1, Reg_write=1, Alu_src=1, ALU_Control=0, rd=1, illegal=0.
- LW x2,0(x1) then ADD x3,x2,x2 back-to-back → one bubble cycle (out_valid=0, in_ready=0), then ADD appears with rs1=rs2=2; LW shows Result_src=01, Load_type=0.
- out_ready=0 for 3 cycles with a BLTU in the register → outputs stable, in_ready=0; BLTU fields: ALU_Control=9, branch_cond=4, Imm_src=2.
- flush asserted while the SW bundle waits with out_ready=0 → out_valid=0 next cycle; the pending input is not captured until flush deasserts.
- RVM_MULDIV_EN, DIV_LAT=8: DIV x5,x6,x7 accepted → ALU_Control=20; in_ready=0 for 8 cycles; a MUL issued immediately after shows ALU_Control=16 with no stall.
- Opcode 0x7F, and (macro off) MUL → illegal=1, Reg_write=0, Mem_Write=0.
